// File: rtl/bday_scan_display_if.sv
// Digit-stream input and multiplexed seven-segment display bundle for bday_scan_display.
interface bday_scan_display_if;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       clear;
    logic [3:0] an;
    logic [6:0] seg;
    logic [2:0] fill;
    logic       full;

    modport master (
        output digit_in, digit_valid, clear,
        input  an, seg, fill, full
    );

    modport slave (
        input  digit_in, digit_valid, clear,
        output an, seg, fill, full
    );
endinterface

// File: rtl/bday_scan_display.sv
// 4-entry digit shift buffer driving a scanned, common-anode 4-digit seven-segment display.
// Positions that have not been loaded are shown blank.
module bday_scan_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    bday_scan_display_if.slave   io_bus
);
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned NPOS   = 4;
    localparam int unsigned FILL_W = 3;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

    logic [DIG_W-1:0]  r_buf [NPOS];
    logic [NPOS-1:0]   r_vld;
    logic [FILL_W-1:0] r_fill;
    logic              r_full;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_sidx;
    logic [NPOS-1:0]   r_an;
    logic [SEG_W-1:0]  r_seg;

    logic              w_div_wrap;
    logic              w_load;
    logic [NPOS-1:0]   w_vld_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic [DIG_W-1:0]  w_dig;
    logic [SEG_W-1:0]  w_seg_nxt;
    logic [NPOS-1:0]   w_an_nxt;

    // Buffer occupancy: clear wins over history, a same-cycle load lands in entry 0.
    always_comb begin
        w_div_wrap = (r_div == DIV_W'(SCAN_DIV - 1));
        w_load     = io_bus.digit_valid;
        w_vld_nxt  = r_vld;
        w_fill_nxt = r_fill;
        if (io_bus.clear) begin
            w_vld_nxt  = {3'b000, w_load};
            w_fill_nxt = w_load ? FILL_W'(1) : FILL_W'(0);
        end else if (w_load) begin
            w_vld_nxt  = {r_vld[NPOS-2:0], 1'b1};
            w_fill_nxt = (r_fill == FILL_W'(NPOS)) ? r_fill : r_fill + FILL_W'(1);
        end
    end

    // Display decode of the currently scanned entry.
    always_comb begin
        w_dig     = r_buf[r_sidx];
        w_an_nxt  = ~(4'b0001 << r_sidx);
        w_seg_nxt = SEG_BLANK;
        if (r_vld[r_sidx]) begin
            case (w_dig)
                4'd0:    w_seg_nxt = 7'h40;
                4'd1:    w_seg_nxt = 7'h79;
                4'd2:    w_seg_nxt = 7'h24;
                4'd3:    w_seg_nxt = 7'h30;
                4'd4:    w_seg_nxt = 7'h19;
                4'd5:    w_seg_nxt = 7'h12;
                4'd6:    w_seg_nxt = 7'h02;
                4'd7:    w_seg_nxt = 7'h78;
                4'd8:    w_seg_nxt = 7'h00;
                4'd9:    w_seg_nxt = 7'h10;
                default: w_seg_nxt = SEG_DASH;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NPOS; i++) r_buf[i] <= '0;
            r_vld  <= '0;
            r_fill <= '0;
            r_full <= 1'b0;
            r_div  <= '0;
            r_sidx <= '0;
            r_an   <= '1;
            r_seg  <= SEG_BLANK;
        end else begin
            r_div <= w_div_wrap ? '0 : r_div + DIV_W'(1);
            if (w_div_wrap) r_sidx <= r_sidx + 2'd1;
            if (w_load) begin
                r_buf[0] <= io_bus.digit_in;
                for (int i = 1; i < NPOS; i++) r_buf[i] <= r_buf[i-1];
            end
            r_vld  <= w_vld_nxt;
            r_fill <= w_fill_nxt;
            r_full <= (w_fill_nxt == FILL_W'(NPOS));
            r_an   <= w_an_nxt;
            r_seg  <= w_seg_nxt;
        end
    end

    assign io_bus.an   = r_an;
    assign io_bus.seg  = r_seg;
    assign io_bus.fill = r_fill;
    assign io_bus.full = r_full;
endmodule

// File: tb/tb_bday_scan_display.sv
// Scoreboard bench for bday_scan_display: stimulus queues per-cycle expectations, a monitor checks them.
module tb_bday_scan_display;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;

    bday_scan_display_if bus();

    bday_scan_display #(.SCAN_DIV(4)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .io_bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
        logic [2:0] fill;
        logic       full;
        bit         chk_disp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] disp [4];
    logic [2:0] fill_exp;
    logic       full_exp;
    int         r0;

    // Monitor: compare the DUT against whatever expectation is due this cycle.
    always @(negedge CLK) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            n_checks++;
            if ((e.chk_disp && (bus.an !== e.an || bus.seg !== e.seg)) ||
                bus.fill !== e.fill || bus.full !== e.full) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got an=%b seg=%h fill=%0d full=%b, want an=%b seg=%h fill=%0d full=%b (disp checked=%0d)",
                         e.name, cyc, bus.an, bus.seg, bus.fill, bus.full,
                         e.an, e.seg, e.fill, e.full, e.chk_disp);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string name, input logic [3:0] an, input logic [6:0] seg,
                        input logic [2:0] fill, input logic full, input bit chk_disp);
        exp_t e;
        e.cyc = cyc + 1; e.name = name; e.an = an; e.seg = seg;
        e.fill = fill; e.full = full; e.chk_disp = chk_disp;
        q.push_back(e);
    endtask

    // Idle cycles: position lit after the j-th edge since reset release is ((j-1)/4)%4.
    task automatic idle_chk(input int n, input string name);
        int p;
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b0;
        for (int i = 0; i < n; i++) begin
            p = ((cyc + 1 - r0 - 1) / 4) % 4;
            push(name, an_tab[p], disp[p], fill_exp, full_exp, 1'b1);
            tick();
        end
    endtask

    task automatic load_step(input logic [3:0] d, input logic clr, input logic vld,
                             input logic [2:0] fill, input logic full, input string name);
        bus.digit_in    = d;
        bus.clear       = clr;
        bus.digit_valid = vld;
        fill_exp = fill;
        full_exp = full;
        push(name, 4'b1111, 7'h7F, fill, full, 1'b0);
        tick();
    endtask

    task automatic do_reset(input int n, input logic [3:0] d);
        RST = 1'b1;
        bus.digit_in    = d;
        bus.digit_valid = 1'b1;
        bus.clear       = 1'b0;
        for (int i = 0; i < n; i++) begin
            push("reset", 4'b1111, 7'h7F, 3'd0, 1'b0, 1'b1);
            tick();
        end
        r0 = cyc;
        RST = 1'b0;
        bus.digit_valid = 1'b0;
        fill_exp = 3'd0;
        full_exp = 1'b0;
    endtask

    initial begin
        bus.digit_in = 4'd0; bus.digit_valid = 1'b0; bus.clear = 1'b0;

        do_reset(3, 4'd5);
        disp = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        idle_chk(17, "scan_empty");

        load_step(4'd1, 1'b0, 1'b1, 3'd1, 1'b0, "load1");
        load_step(4'd9, 1'b0, 1'b1, 3'd2, 1'b0, "load9");
        load_step(4'd0, 1'b0, 1'b1, 3'd3, 1'b0, "load0");
        load_step(4'd8, 1'b0, 1'b1, 3'd4, 1'b1, "load8");
        disp = '{7'h00, 7'h40, 7'h10, 7'h79};
        idle_chk(16, "disp_1908");

        load_step(4'd5, 1'b0, 1'b1, 3'd4, 1'b1, "overflow5");
        disp = '{7'h12, 7'h00, 7'h40, 7'h10};
        idle_chk(16, "disp_9085");

        load_step(4'd7, 1'b1, 1'b1, 3'd1, 1'b0, "clear_load7");
        disp = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
        idle_chk(16, "disp_7");

        load_step(4'd0, 1'b1, 1'b0, 3'd0, 1'b0, "clear_only");
        disp = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        idle_chk(8, "disp_cleared");

        do_reset(1, 4'd3);
        load_step(4'd12, 1'b0, 1'b1, 3'd1, 1'b0, "load12");
        disp = '{7'h3F, 7'h7F, 7'h7F, 7'h7F};
        idle_chk(16, "disp_dash");

        @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bday_scan_display.md
# bday_scan_display

Downstream display stage for the birthday-digit generator. Captures the 4-bit digit stream it produces into a 4-entry shift buffer and drives a multiplexed 4-digit, common-anode seven-segment display. Scans one digit position at a time at a programmable rate. Digit positions not yet loaded are blanked.

## Interface
Parameters:
- SCAN_DIV, default 4: clock cycles each digit position stays lit; legal range 1..65535.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- digit_in  in  4  digit value from the upstream generator; 0-9 are valid digits, 10-15 are out of range.
- digit_valid  in  1  when high on a rising edge, digit_in is captured into the buffer.
- clear  in  1  synchronous clear of the buffer.
- an  out  4  anode enables, active-low, one-hot; an[i] selects position i, where 0 is rightmost.
- seg  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- fill  out  3  number of loaded positions, 0..4.
- full  out  1  high when fill==4.

## Operation
- Buffer: four 4-bit entries, buf[0..3], plus one valid bit per entry.
- Load (digit_valid=1, clear=0):
  - buf[3]←buf[2], buf[2]←buf[1], buf[1]←buf[0], buf[0]←digit_in; valid bits shift the same way.
  - fill increments and saturates at 4.
  - When already full, the oldest digit is discarded.
- Clear (clear=1, digit_valid=0): all valid bits and fill go to 0. Entry contents are don't-care.
- clear=1 and digit_valid=1 in the same cycle: clear and load together. buf[0]←digit_in with only entry 0 valid; fill=1.
- Divider: counter div runs 0..SCAN_DIV-1 and increments every cycle. On reaching SCAN_DIV-1 it returns to 0 and scan index sidx (2 bits) increments, wrapping 3→0. With SCAN_DIV=1, sidx advances every cycle.
- Decode of entry buf[sidx]:
  - Entry not valid: blank, 7'h7F.
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10.
  - 10-15→dash, 7'h3F (segment g only).
- an = ~(4'b0001 << sidx).
- fill and full are registered state, not decoded from outputs.

## Timing
- Reset values, held while RST=1:
  - an=4'b1111, all digits off.
  - seg=7'h7F.
  - fill=0, full=0, div=0, sidx=0, all valid bits 0.
- an and seg are registered. Their value after edge t is computed from sidx and the buffer as they stand before edge t, so display latency is 1 cycle.
- The first edge with RST=0 drives an=4'b1110 and seg=7'h7F.
- A digit loaded at edge t is visible at edge t+1 when its position is being scanned at that point.
- fill and full update on the same edge as the load or clear.
- Scan period is 4·SCAN_DIV cycles. Each position is lit for exactly SCAN_DIV consecutive cycles.
- Buffer activity has no effect on div or sidx. Load and clear never disturb the scan.
- RST asserted mid-scan or mid-load: the next edge returns every register to its reset value. The load in that cycle is dropped.
- No handshake back-pressure: every digit_valid pulse is accepted, one digit per cycle maximum.

## Test plan
- Reset: hold RST 3 cycles with digit_valid=1 → an=1111, seg=7F, fill=0 throughout. First edge after release → an=1110, seg=7F.
- Scan rotation, SCAN_DIV=4, empty buffer → an cycles 1110,1101,1011,0111, each for 4 cycles. Wrap back to 1110 at cycle 17. seg stays 7F.
- Load 1,9,0,8 on four consecutive cycles → fill 1,2,3,4; full=1 after the 4th. During the scan: position 3 shows 79, position 2 shows 10, position 1 shows 40, position 0 shows 00.
- Overflow: with the buffer holding 1,9,0,8, load 5 → fill stays 4; positions 3..0 show 9,0,8,5 (10,40,00,12).
- Out-of-range and blank: after reset, load 12 → position 0 shows 3F; positions 1-3 show 7F.
- Clear and load together: with a full buffer, assert clear and digit_valid with digit_in=7 → fill=1, position 0 shows 78, others 7F. Clear alone next cycle → fill=0, all 7F.
